// File: rtl/int_ctrl_if.sv
// Bus bundle for int_ctrl: interrupt sources, register port and CPU trap handshake.
// The slave modport is the controller; the master modport is the CPU/system side.
interface int_ctrl_if;
  logic [3:0]  irq_src;
  logic        reg_we;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        int_req;
  logic [1:0]  int_id;
  logic [31:0] int_vec;
  logic        int_ack;
  logic        int_done;

  modport slave (
    input  irq_src, reg_we, reg_addr, reg_wdata, int_ack, int_done,
    output reg_rdata, int_req, int_id, int_vec
  );

  modport master (
    output irq_src, reg_we, reg_addr, reg_wdata, int_ack, int_done,
    input  reg_rdata, int_req, int_id, int_vec
  );
endinterface

// File: rtl/int_ctrl.sv
// Four-source edge-triggered interrupt controller with vectored, non-nesting request/ack/done handshake.
// Optional: define INT_CTRL_ROUND_ROBIN_EN for round-robin arbitration (default is fixed, lowest index wins).
module int_ctrl #(
  parameter logic [31:0] VEC_BASE   = 32'h0000_0004,
  parameter logic [31:0] VEC_STRIDE = 32'd4
) (
  input logic       clk,
  input logic       rst,
  int_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_gie;
  logic [3:0]  r_mask;
  logic [3:0]  r_pending;
  logic [3:0]  r_overflow;
  logic [3:0]  r_irqPrev;
  logic        r_intReq;
  logic [1:0]  r_intId;
  logic [31:0] r_intVec;

  logic [3:0]  w_edge;
  logic [3:0]  w_eligible;
  logic [3:0]  w_pendClr;
  logic [3:0]  w_ovfClr;
  logic [3:0]  w_ackClr;
  logic [1:0]  w_winner;
  logic [31:0] w_rdata;
  logic        w_unused;

  always_comb begin
    w_edge     = bus.irq_src & ~r_irqPrev;
    w_eligible = r_pending & r_mask & {4{r_gie}};
    w_pendClr  = (bus.reg_we && bus.reg_addr == 2'd2) ? bus.reg_wdata[3:0] : 4'd0;
    w_ovfClr   = (bus.reg_we && bus.reg_addr == 2'd3) ? bus.reg_wdata[7:4] : 4'd0;
    w_ackClr   = (r_state == REQ && bus.int_ack) ? (4'b0001 << r_intId) : 4'd0;
  end

`ifdef INT_CTRL_ROUND_ROBIN_EN
  logic [1:0] r_lastGrant;

  // Search starts just after the last granted source; lowest offset wins.
  always_comb begin
    logic [1:0] idx;
    idx      = 2'd0;
    w_winner = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = r_lastGrant + 2'(k + 1);
      if (w_eligible[idx]) w_winner = idx;
    end
  end
`else
  always_comb begin
    w_winner = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (w_eligible[k]) w_winner = 2'(k);
    end
  end
`endif

  // New edges are ORed in last so a same-cycle set beats any clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irqPrev  <= 4'd0;
      r_pending  <= 4'd0;
      r_overflow <= 4'd0;
      r_gie      <= 1'b0;
      r_mask     <= 4'd0;
    end else begin
      r_irqPrev  <= bus.irq_src;
      r_pending  <= (r_pending & ~w_pendClr & ~w_ackClr) | w_edge;
      r_overflow <= (r_overflow & ~w_ovfClr) | (w_edge & r_pending);
      if (bus.reg_we && bus.reg_addr == 2'd0) r_gie  <= bus.reg_wdata[0];
      if (bus.reg_we && bus.reg_addr == 2'd1) r_mask <= bus.reg_wdata[3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_intReq <= 1'b0;
      r_intId  <= 2'd0;
      r_intVec <= VEC_BASE;
`ifdef INT_CTRL_ROUND_ROBIN_EN
      r_lastGrant <= 2'd3;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_eligible != 4'd0) begin
            r_state  <= REQ;
            r_intReq <= 1'b1;
            r_intId  <= w_winner;
            r_intVec <= VEC_BASE + VEC_STRIDE * {30'd0, w_winner};
          end
        end
        REQ: begin
          if (bus.int_ack) begin
            r_state  <= SERVICE;
            r_intReq <= 1'b0;
`ifdef INT_CTRL_ROUND_ROBIN_EN
            r_lastGrant <= r_intId;
`endif
          end
        end
        SERVICE: begin
          if (bus.int_done) r_state <= IDLE;
        end
        default: begin
          r_state  <= IDLE;
          r_intReq <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    case (bus.reg_addr)
      2'd0:    w_rdata = {31'd0, r_gie};
      2'd1:    w_rdata = {28'd0, r_mask};
      2'd2:    w_rdata = {28'd0, r_pending};
      default: w_rdata = {24'd0, r_overflow, r_state, r_intId};
    endcase
  end

  assign w_unused      = ^bus.reg_wdata[31:8];
  assign bus.reg_rdata = w_rdata;
  assign bus.int_req   = r_intReq;
  assign bus.int_id    = r_intId;
  assign bus.int_vec   = r_intVec;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: table of single-edge arbitration vectors plus
// hand-written handshake, overflow, masking and reset sequences, with a grant scoreboard.
module tb_int_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   testsRun = 0;
  int   testsFailed = 0;

  int_ctrl_if bus ();

  int_ctrl #(
    .VEC_BASE  (32'h0000_0004),
    .VEC_STRIDE(32'd4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] vec;
  } grant_t;

  typedef struct {
    logic [3:0] irq;
    logic [3:0] mask;
    logic       gie;
    logic       expReq;
    logic [1:0] expId;
    logic [3:0] expPend;
  } vector_t;

  grant_t  expQ[$];
  vector_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic readReg(input logic [1:0] a, output logic [31:0] d);
    bus.reg_addr = a;
    #1;
    d = bus.reg_rdata;
  endtask

  task automatic checkReg(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    readReg(a, d);
    checkOutput(name, d, exp);
  endtask

  task automatic writeReg(input logic [1:0] a, input logic [31:0] d);
    bus.reg_we    = 1'b1;
    bus.reg_addr  = a;
    bus.reg_wdata = d;
    tick();
    bus.reg_we    = 1'b0;
    bus.reg_wdata = 32'd0;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expQ.delete();
  endtask

  // Rising edge on the given sources, then one idle-low cycle so a later pulse is a fresh edge.
  task automatic pulse(input logic [3:0] src);
    bus.irq_src = src;
    tick();
    bus.irq_src = 4'd0;
    tick();
  endtask

  task automatic ackPulse();
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
  endtask

  task automatic donePulse();
    bus.int_done = 1'b1;
    tick();
    bus.int_done = 1'b0;
  endtask

  task automatic pushGrant(input logic [1:0] id);
    grant_t g;
    g.id  = id;
    g.vec = 32'h0000_0004 + 32'(id) * 32'd4;
    expQ.push_back(g);
  endtask

  // Waits a bounded number of cycles for int_req, then pops and compares the expected grant.
  task automatic waitGrant(input string name, input int maxCycles);
    grant_t g;
    int n;
    n = 0;
    while (!bus.int_req && n < maxCycles) begin
      tick();
      n++;
    end
    if (!bus.int_req) begin
      checkOutput({name, " req timeout"}, {31'd0, bus.int_req}, 32'd1);
      if (expQ.size() != 0) g = expQ.pop_front();
    end else if (expQ.size() == 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s: got unexpected grant id %0d, expected none", name, bus.int_id);
    end else begin
      g = expQ.pop_front();
      checkOutput({name, " id"}, {30'd0, bus.int_id}, {30'd0, g.id});
      checkOutput({name, " vec"}, bus.int_vec, g.vec);
    end
  endtask

  task automatic applyStimulus(input int i);
    string tag;
    tag = $sformatf("vec%0d", i);
    applyReset();
    writeReg(2'd0, {31'd0, vecs[i].gie});
    writeReg(2'd1, {28'd0, vecs[i].mask});
    if (vecs[i].expReq) pushGrant(vecs[i].expId);
    bus.irq_src = vecs[i].irq;
    tick();
    bus.irq_src = 4'd0;
    checkOutput({tag, " latency"}, {31'd0, bus.int_req}, 32'd0);
    tick();
    checkOutput({tag, " req"}, {31'd0, bus.int_req}, {31'd0, vecs[i].expReq});
    if (vecs[i].expReq) waitGrant(tag, 0);
    checkReg({tag, " pending"}, 2'd2, {28'd0, vecs[i].expPend});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.irq_src   = 4'd0;
    bus.reg_we    = 1'b0;
    bus.reg_addr  = 2'd0;
    bus.reg_wdata = 32'd0;
    bus.int_ack   = 1'b0;
    bus.int_done  = 1'b0;

    vecs[0] = '{4'b0001, 4'hF,    1'b1, 1'b1, 2'd0, 4'b0001};
    vecs[1] = '{4'b0110, 4'hF,    1'b1, 1'b1, 2'd1, 4'b0110};
    vecs[2] = '{4'b1000, 4'hF,    1'b1, 1'b1, 2'd3, 4'b1000};
    vecs[3] = '{4'b0100, 4'b0001, 1'b1, 1'b0, 2'd0, 4'b0100};
    vecs[4] = '{4'b1111, 4'b1100, 1'b1, 1'b1, 2'd2, 4'b1111};
    vecs[5] = '{4'b0010, 4'hF,    1'b0, 1'b0, 2'd0, 4'b0010};
    vecs[6] = '{4'b1010, 4'b1000, 1'b1, 1'b1, 2'd3, 4'b1010};

    repeat (2) tick();

    // Reset state
    applyReset();
    checkOutput("reset int_req", {31'd0, bus.int_req}, 32'd0);
    checkOutput("reset int_id", {30'd0, bus.int_id}, 32'd0);
    checkOutput("reset int_vec", bus.int_vec, 32'h0000_0004);
    checkReg("reset CTRL", 2'd0, 32'd0);
    checkReg("reset MASK", 2'd1, 32'd0);
    checkReg("reset PENDING", 2'd2, 32'd0);
    checkReg("reset STATUS", 2'd3, 32'd0);

    for (int i = 0; i < 7; i++) applyStimulus(i);

    // Basic handshake, hold-stable in REQ, ignored ack/done outside their states
    applyReset();
    writeReg(2'd0, 32'd1);
    writeReg(2'd1, 32'hF);
    pushGrant(2'd0);
    bus.irq_src = 4'b0001;
    tick();
    bus.irq_src = 4'd0;
    checkOutput("A latency", {31'd0, bus.int_req}, 32'd0);
    tick();
    waitGrant("A grant", 0);
    writeReg(2'd1, 32'h0);
    writeReg(2'd0, 32'h0);
    donePulse();
    checkOutput("A hold req", {31'd0, bus.int_req}, 32'd1);
    checkOutput("A hold vec", bus.int_vec, 32'h0000_0004);
    checkReg("A STATUS in REQ", 2'd3, 32'h4);
    ackPulse();
    checkOutput("A req after ack", {31'd0, bus.int_req}, 32'd0);
    checkReg("A PENDING after ack", 2'd2, 32'd0);
    checkReg("A STATUS in SERVICE", 2'd3, 32'h8);
    ackPulse();
    checkReg("A stray ack", 2'd3, 32'h8);
    donePulse();
    checkReg("A STATUS after done", 2'd3, 32'h0);

    // Simultaneous edges on 1 and 2 after source 1 was last granted
    applyReset();
    writeReg(2'd0, 32'd1);
    writeReg(2'd1, 32'hF);
    pushGrant(2'd1);
    pulse(4'b0010);
    waitGrant("B single", 4);
    ackPulse();
    donePulse();
`ifdef INT_CTRL_ROUND_ROBIN_EN
    pushGrant(2'd2);
    pushGrant(2'd1);
`else
    pushGrant(2'd1);
    pushGrant(2'd2);
`endif
    pulse(4'b0110);
    waitGrant("B first", 4);
    ackPulse();
    donePulse();
    checkOutput("B no issue on done", {31'd0, bus.int_req}, 32'd0);
    tick();
    waitGrant("B second", 0);
    ackPulse();
    donePulse();

    // Masked source becomes eligible when MASK widens
    applyReset();
    writeReg(2'd0, 32'd1);
    writeReg(2'd1, 32'h1);
    pulse(4'b0100);
    tick();
    checkOutput("C masked req", {31'd0, bus.int_req}, 32'd0);
    checkReg("C PENDING", 2'd2, 32'h4);
    pushGrant(2'd2);
    writeReg(2'd1, 32'h5);
    waitGrant("C unmasked", 3);

    // Overflow and set-wins-over-clear
    applyReset();
    pulse(4'b0010);
    pulse(4'b0010);
    checkReg("D STATUS overflow", 2'd3, 32'h20);
    checkReg("D PENDING single", 2'd2, 32'h2);
    writeReg(2'd3, 32'h20);
    checkReg("D overflow cleared", 2'd3, 32'h0);
    bus.irq_src = 4'b0010;
    writeReg(2'd2, 32'h2);
    bus.irq_src = 4'd0;
    checkReg("D pending set wins", 2'd2, 32'h2);
    checkReg("D overflow on pending", 2'd3, 32'h20);
    tick();
    bus.irq_src = 4'b0010;
    writeReg(2'd3, 32'h20);
    bus.irq_src = 4'd0;
    checkReg("D overflow set wins", 2'd3, 32'h20);
    writeReg(2'd2, 32'h2);
    checkReg("D pending cleared", 2'd2, 32'h0);

    // Reset during SERVICE and REQ
    applyReset();
    writeReg(2'd0, 32'd1);
    writeReg(2'd1, 32'hF);
    pushGrant(2'd0);
    pulse(4'b0001);
    waitGrant("E grant", 2);
    ackPulse();
    checkReg("E STATUS SERVICE", 2'd3, 32'h8);
    applyReset();
    checkOutput("E req after rst", {31'd0, bus.int_req}, 32'd0);
    checkReg("E STATUS after rst", 2'd3, 32'h0);
    donePulse();
    checkReg("E done ignored", 2'd3, 32'h0);
    pulse(4'b1000);
    tick();
    checkOutput("E GIE off req", {31'd0, bus.int_req}, 32'd0);
    checkReg("E PENDING GIE off", 2'd2, 32'h8);
    pushGrant(2'd3);
    writeReg(2'd1, 32'h8);
    writeReg(2'd0, 32'd1);
    waitGrant("E late grant", 3);
    applyReset();
    checkOutput("E req after rst in REQ", {31'd0, bus.int_req}, 32'd0);

    checkOutput("scoreboard empty", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 The block SHALL have parameter VEC_BASE, default 32'h0000_0004, the address of vector 0.
REQ-002 The block SHALL have parameter VEC_STRIDE, default 4, the byte spacing between vectors.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 irq_src  input  4  level interrupt sources: [0] timer, [1] buttons, [2] UART RX, [3] UART TX done.
REQ-006 reg_we  input  1  register write strobe, one cycle.
REQ-007 reg_addr  input  2  register select.
REQ-008 reg_wdata  input  32  register write data.
REQ-009 reg_rdata  output  32  register read data, combinational from reg_addr.
REQ-010 int_req  output  1  interrupt request to the CPU pipeline.
REQ-011 int_id  output  2  granted source index.
REQ-012 int_vec  output  32  handler address, VEC_BASE + VEC_STRIDE*int_id.
REQ-013 int_ack  input  1  CPU has taken the trap (pipeline flushed, PC redirected).
REQ-014 int_done  input  1  CPU has executed the return-from-interrupt.

Function
REQ-015 Rising edge of irq_src[i] (current 1, registered previous 0) SHALL set pending[i] on the next clock.
REQ-016 An edge on an already-pending source SHALL set overflow[i] (sticky) and SHALL NOT queue a second event.
REQ-017 Register map: 0 CTRL (bit0 GIE); 1 MASK[3:0]; 2 PENDING[3:0] write-1-to-clear; 3 STATUS: [1:0] active id, [3:2] state, [7:4] overflow (write-1-to-clear). Unused bits read 0.
REQ-018 When a new edge and a W1C clear hit the same pending or overflow bit in one cycle, set SHALL win.
REQ-019 Eligible = pending & MASK, gated by GIE.
REQ-020 FSM states IDLE=0, REQ=1, SERVICE=2.
REQ-021 IDLE -> REQ when eligible is non-zero; the winner is latched into int_id; int_req rises on the same clock.
REQ-022 In REQ, int_req, int_id and int_vec SHALL hold stable until int_ack, even if MASK, GIE or pending change.
REQ-023 REQ -> SERVICE on int_ack; the same clock SHALL clear pending[int_id] and drop int_req.
REQ-024 SERVICE -> IDLE on int_done; no new request SHALL issue in the cycle int_done is sampled, so re-arbitration occurs no earlier than the following clock.
REQ-025 No nesting: new edges in SERVICE SHALL only set pending or overflow.
REQ-026 int_ack outside REQ and int_done outside SERVICE SHALL be ignored.
REQ-027 Minimum latency from source edge to int_req SHALL be 2 clocks.

Reset
REQ-028 On rst: state IDLE; int_req=0, int_id=0, int_vec=VEC_BASE; GIE, MASK, pending, overflow and the edge-detect registers all 0; last_grant=3.
REQ-029 rst asserted in REQ or SERVICE SHALL abandon the transaction; int_req SHALL be 0 on the next clock.

Configuration
REQ-030 With INT_CTRL_ROUND_ROBIN_EN defined, the search SHALL start at index last_grant+1 mod 4, and last_grant SHALL update on int_ack.
REQ-031 Without INT_CTRL_ROUND_ROBIN_EN, priority SHALL be fixed (lowest index wins) and last_grant SHALL be unused.

Verification
REQ-032 GIE=1, MASK=4'hF, pulse irq_src[0] -> int_req=1, int_id=0, int_vec=32'h4 two clocks later; int_ack -> PENDING=0; int_done -> IDLE.
REQ-033 Edges on sources 1 and 2 in the same cycle, fixed priority -> grant 1, then after int_done grant 2; with round-robin and last_grant=1 -> grant 2 first.
REQ-034 MASK=4'h1 and a source-2 edge -> no int_req, PENDING=4'h4; then write MASK=4'h5 -> int_req with int_id=2.
REQ-035 A second source-1 edge while pending[1]=1 -> STATUS[5]=1; write 32'h20 to addr 3 -> STATUS[5]=0.
REQ-036 rst during SERVICE -> next clock int_req=0, STATUS=0, a later int_done is ignored; pending edge with GIE=0 -> no request.
